// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter
// Shares one single-port synchronous SRAM between two requesters (A, B).
// Arbitration is done every cycle: a lone requester always wins, and a
// contested cycle goes to the side named by the priority register, which
// then flips to the loser. At most one access is issued per cycle and read
// data is returned to the winning side exactly one cycle after its grant.
//
// Ports
//   clk_i, rstn_i             clock (rising edge), synchronous active-low reset
//   a_* / b_*                 requester interfaces: valid/ready handshake,
//                             we (1 = write), addr, wdata; rvalid/rdata response
//   cenb_o, wenb_o            SRAM chip / write enables, active low
//   addr_o, d_o               SRAM address and write data
//   q_i                       SRAM read data (1-cycle latency)
module sram_rr_arbiter #(
  parameter  int WIDTH = 32,
  parameter  int SIZE  = 256,
  localparam int AW    = $clog2(SIZE)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             a_valid_i,
  output logic             a_ready_o,
  input  logic             a_we_i,
  input  logic [AW-1:0]    a_addr_i,
  input  logic [WIDTH-1:0] a_wdata_i,
  output logic             a_rvalid_o,
  output logic [WIDTH-1:0] a_rdata_o,
  input  logic             b_valid_i,
  output logic             b_ready_o,
  input  logic             b_we_i,
  input  logic [AW-1:0]    b_addr_i,
  input  logic [WIDTH-1:0] b_wdata_i,
  output logic             b_rvalid_o,
  output logic [WIDTH-1:0] b_rdata_o,
  output logic             cenb_o,
  output logic             wenb_o,
  output logic [AW-1:0]    addr_o,
  output logic [WIDTH-1:0] d_o,
  input  logic [WIDTH-1:0] q_i
);

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_e;

  side_e prio;
  logic  rd_pend;
  side_e rd_side;

  logic  gnt_a;
  logic  gnt_b;
  logic  gnt_any;
  logic  gnt_we;
  side_e gnt_side;

  // Grant decision; everything is suppressed while reset is held low.
  always_comb begin
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    gnt_any  = 1'b0;
    gnt_we   = 1'b0;
    gnt_side = SIDE_A;
    if (rstn_i) begin
      gnt_a = a_valid_i && (!b_valid_i || (prio == SIDE_A));
      gnt_b = b_valid_i && (!a_valid_i || (prio == SIDE_B));
    end
    gnt_any  = gnt_a || gnt_b;
    gnt_side = gnt_b ? SIDE_B : SIDE_A;
    gnt_we   = gnt_b ? b_we_i : (gnt_a && a_we_i);
  end

  // Memory drive and handshake outputs.
  always_comb begin
    a_ready_o = gnt_a;
    b_ready_o = gnt_b;
    cenb_o    = 1'b1;
    wenb_o    = 1'b1;
    addr_o    = '0;
    d_o       = '0;
    if (gnt_a) begin
      cenb_o = 1'b0;
      wenb_o = ~a_we_i;
      addr_o = a_addr_i;
      d_o    = a_wdata_i;
    end else if (gnt_b) begin
      cenb_o = 1'b0;
      wenb_o = ~b_we_i;
      addr_o = b_addr_i;
      d_o    = b_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      prio    <= SIDE_A;
      rd_pend <= 1'b0;
      rd_side <= SIDE_A;
    end else begin
      // A read is pending for exactly the cycle after its grant.
      rd_pend <= gnt_any && !gnt_we;
      if (gnt_any) begin
        prio <= (gnt_side == SIDE_A) ? SIDE_B : SIDE_A;
        if (!gnt_we) begin
          rd_side <= gnt_side;
        end
      end
    end
  end

  // Response: rstn_i gating drops a response whose grant preceded reset.
  always_comb begin
    a_rvalid_o = rstn_i && rd_pend && (rd_side == SIDE_A);
    b_rvalid_o = rstn_i && rd_pend && (rd_side == SIDE_B);
    a_rdata_o  = a_rvalid_o ? q_i : '0;
    b_rdata_o  = b_rvalid_o ? q_i : '0;
  end

endmodule
